sky130_fd_io__hvc_pwrgood_seq: RTL



---
 rtl/sky130_fd_io__pwrseq_pkg.sv | 33 +++
 rtl/sky130_fd_io__pwrseq_deb.sv | 60 ++++++
 rtl/sky130_fd_io__hvc_pwrgood_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sky130_fd_io__pwrseq_pkg.sv
// ============================================================================
// Module      : sky130_fd_io__pwrseq_pkg
// Description : Shared state encodings and output bundle for the HVC
//               power-good sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sky130_fd_io__pwrseq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_IO_UP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_CORE_UP = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN     = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT   = 3'd4;

  // Registered output bundle, decoded from the next state.
  typedef struct packed {
    logic clamp_en;
    logic io_en;
    logic analog_en;
    logic pwrgood;
    logic fault;
  } pwrseq_out_t;

  // Safe value: clamp armed, everything else released.
  localparam pwrseq_out_t PWRSEQ_OUT_RST = '{clamp_en: 1'b1, default: 1'b0};

endpackage

`default_nettype wire

// File: rtl/sky130_fd_io__pwrseq_deb.sv
// ============================================================================
// Module      : sky130_fd_io__pwrseq_deb
// Description : 2-flop synchronizer plus saturating debounce counter for one
//               raw supply-present flag. Slow gain, fast loss.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sky130_fd_io__pwrseq_deb #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_qual
);

  localparam logic [CNT_W-1:0] c_deb = CNT_W'(DEB_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Two-stage synchronizer for the asynchronous comparator flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive synced highs, saturating; any synced low clears.
  always_comb begin
    w_cnt_nxt = '0;
    if (r_sync2) begin
      w_cnt_nxt = (r_cnt == c_deb) ? r_cnt : r_cnt + 1'b1;
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Qualified in the cycle the DEB_CYCLES-th consecutive high sample is
  // taken, and dropped in the very cycle a synced low appears.
  assign o_qual = (w_cnt_nxt == c_deb);

endmodule

`default_nettype wire

// File: rtl/sky130_fd_io__hvc_pwrgood_seq.sv
// ============================================================================
// Module      : sky130_fd_io__hvc_pwrgood_seq
// Description : HVC power-good sequencer. Qualifies VDDIO/VCCD/VDDA flags,
//               releases IO hold, enables analog, asserts PWRGOOD and keeps
//               the ESD clamp armed whenever supplies are not qualified.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sky130_fd_io__hvc_pwrgood_seq
  import sky130_fd_io__pwrseq_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 8
) (
  input  logic               CLK,
  input  logic               RESET_B,
  input  logic               VDDIO_PRESENT,
  input  logic               VCCD_PRESENT,
  input  logic               VDDA_PRESENT,
  input  logic               CLR_FAULT,
  output logic               CLAMP_EN,
  output logic               IO_EN,
  output logic               ANALOG_EN,
  output logic               PWRGOOD,
  output logic               FAULT,
  output logic [STATE_W-1:0] STATE
);

  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);

  logic               w_q_vddio;
  logic               w_q_vccd;
  logic               w_q_vdda;
  logic               w_loss;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   r_settle;
  pwrseq_out_t        w_out;
  pwrseq_out_t        r_out;

  sky130_fd_io__pwrseq_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_vddio (
    .clk(CLK), .rst_n(RESET_B), .i_raw(VDDIO_PRESENT), .o_qual(w_q_vddio)
  );

  sky130_fd_io__pwrseq_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_vccd (
    .clk(CLK), .rst_n(RESET_B), .i_raw(VCCD_PRESENT), .o_qual(w_q_vccd)
  );

  sky130_fd_io__pwrseq_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_vdda (
    .clk(CLK), .rst_n(RESET_B), .i_raw(VDDA_PRESENT), .o_qual(w_q_vdda)
  );

  // VDDA is optional; only VDDIO and VCCD count as a loss.
  assign w_loss = !w_q_vddio || !w_q_vccd;

  // State register.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Settle counter: zero outside CORE_UP, so it is cleared on entry.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_settle <= '0;
    end else if (r_state != ST_CORE_UP) begin
      r_settle <= '0;
    end else if (r_settle != c_settle_last) begin
      r_settle <= r_settle + 1'b1;
    end
  end

  // Next-state logic; loss is checked before any advance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_q_vddio) w_state_nxt = ST_IO_UP;
      end
      ST_IO_UP: begin
        if (!w_q_vddio)    w_state_nxt = ST_IDLE;
        else if (w_q_vccd) w_state_nxt = ST_CORE_UP;
      end
      ST_CORE_UP: begin
        if (w_loss)                           w_state_nxt = ST_FAULT;
        else if (r_settle == c_settle_last)   w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_loss) w_state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        if (CLR_FAULT) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so outputs move with STATE.
  always_comb begin
    w_out = PWRSEQ_OUT_RST;
    case (w_state_nxt)
      ST_IO_UP: begin
        w_out.io_en = 1'b1;
      end
      ST_CORE_UP: begin
        w_out.io_en    = 1'b1;
        w_out.clamp_en = 1'b0;
      end
      ST_RUN: begin
        w_out.io_en     = 1'b1;
        w_out.clamp_en  = 1'b0;
        w_out.pwrgood   = 1'b1;
        w_out.analog_en = w_q_vdda;
      end
      ST_FAULT: begin
        w_out.fault = 1'b1;
      end
      default: w_out = PWRSEQ_OUT_RST;
    endcase
  end

  // Output register.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_out <= PWRSEQ_OUT_RST;
    end else begin
      r_out <= w_out;
    end
  end

  assign CLAMP_EN  = r_out.clamp_en;
  assign IO_EN     = r_out.io_en;
  assign ANALOG_EN = r_out.analog_en;
  assign PWRGOOD   = r_out.pwrgood;
  assign FAULT     = r_out.fault;
  assign STATE     = r_state;

endmodule

`default_nettype wire
